aes_sram1_controller: RTL and testbench

//  Sequences 128-bit block transfers for the AES chip. Reads each input block from
//  off-chip SRAM1 and, once the AES core reports the block processed, writes the

---
 rtl/aes_sram1_controller.sv | 108 ++++++++++
 tb/tb_aes_sram1_controller.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_sram1_controller.sv
// Block-transfer sequencer for the AES chip: reads 128-bit blocks from SRAM1
// and writes each processed result back to SRAM2 at the same address.
//
// state | meaning
// IDLE  | waiting for enable; addresses hold their last values
// READ  | r_en high for one cycle at the current block address
// WAIT  | waiting for the AES core to report the block done (flag_40)
// WRITE | w_en high for one cycle at the current block address
// NEXT  | advance to the next block or finish
// DONE  | de_fin pulse, then back to IDLE
module aes_sram1_controller #(
  parameter int ADDR_BITS   = 8,
  parameter int BLOCK_WORDS = 8
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 enable,
  input  logic                 en_or_de,
  input  logic [ADDR_BITS-1:0] s_addr,
  input  logic [ADDR_BITS-1:0] loc,
  input  logic                 flag_40,
  output logic                 r_en,
  output logic                 w_en,
  output logic [ADDR_BITS-1:0] r_addr,
  output logic [ADDR_BITS-1:0] w_addr,
  output logic                 de_fin,
  output logic                 mode_q
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    NEXT  = 3'd4,
    DONE  = 3'd5
  } state_t;

  localparam logic [ADDR_BITS:0] STEP = (ADDR_BITS+1)'(BLOCK_WORDS);

  state_t                 state, state_d;
  logic [ADDR_BITS-1:0]   cur, cur_d;
  logic [ADDR_BITS-1:0]   last, last_d;
  logic                   mode_d;
  logic [ADDR_BITS:0]     cur_inc;
  logic                   at_end;

  // The extra carry bit catches the step past the top of the address space.
  assign cur_inc = {1'b0, cur} + STEP;
  assign at_end  = (cur >= last) || cur_inc[ADDR_BITS];

  always_comb begin
    state_d = state;
    cur_d   = cur;
    last_d  = last;
    mode_d  = mode_q;
    case (state)
      IDLE: begin
        if (enable) begin
          cur_d   = s_addr;
          last_d  = loc;
          mode_d  = en_or_de;
          state_d = READ;
        end
      end
      READ:  state_d = WAIT;
      WAIT:  if (flag_40) state_d = WRITE;
      WRITE: state_d = NEXT;
      NEXT: begin
        if (at_end) begin
          state_d = DONE;
        end else begin
          cur_d   = cur_inc[ADDR_BITS-1:0];
          state_d = READ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Strobes and addresses are registered from the next state so they line up
  // exactly with the state they belong to.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state  <= IDLE;
      cur    <= '0;
      last   <= '0;
      mode_q <= 1'b0;
      r_en   <= 1'b0;
      w_en   <= 1'b0;
      de_fin <= 1'b0;
      r_addr <= '0;
      w_addr <= '0;
    end else begin
      state  <= state_d;
      cur    <= cur_d;
      last   <= last_d;
      mode_q <= mode_d;
      r_en   <= (state_d == READ);
      w_en   <= (state_d == WRITE);
      de_fin <= (state_d == DONE);
      if (state_d == READ)  r_addr <= cur_d;
      if (state_d == WRITE) w_addr <= cur_d;
    end
  end

endmodule

// File: tb/tb_aes_sram1_controller.sv
// Self-checking bench for aes_sram1_controller: table-driven jobs, random jobs
// against a block-list reference model, and reset/hold-enable sequences.
module tb_aes_sram1_controller;

  logic       clk;
  logic       n_rst;
  logic       enable;
  logic       en_or_de;
  logic [7:0] s_addr;
  logic [7:0] loc;
  logic       flag_40;
  logic       r_en;
  logic       w_en;
  logic [7:0] r_addr;
  logic [7:0] w_addr;
  logic       de_fin;
  logic       mode_q;

  int tests = 0;
  int fails = 0;
  int rd_cnt = 0;
  int wr_cnt = 0;

  aes_sram1_controller #(.ADDR_BITS(8), .BLOCK_WORDS(8)) dut (
    .clk(clk), .n_rst(n_rst), .enable(enable), .en_or_de(en_or_de),
    .s_addr(s_addr), .loc(loc), .flag_40(flag_40),
    .r_en(r_en), .w_en(w_en), .r_addr(r_addr), .w_addr(w_addr),
    .de_fin(de_fin), .mode_q(mode_q)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(negedge clk) begin
    if (n_rst) begin
      if (r_en) rd_cnt++;
      if (w_en) wr_cnt++;
      if (r_en && w_en) begin
        tests++;
        fails++;
        $display("FAIL strobe_overlap: r_en=%0b w_en=%0b, required not both high", r_en, w_en);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference: the list of block addresses a job must touch, in order.
  task automatic run_job(input logic [7:0] s, input logic [7:0] l, input logic m,
                         input bit hold);
    logic [7:0] q[$];
    int a;
    int n;
    int r0;
    int w0;
    a = int'(s);
    forever begin
      q.push_back(8'(a));
      if (a >= int'(l) || a + 8 > 255) break;
      a += 8;
    end
    r0 = rd_cnt;
    w0 = wr_cnt;
    enable   = 1'b1;
    s_addr   = s;
    loc      = l;
    en_or_de = m;
    flag_40  = 1'($urandom % 2);
    tick();
    enable = 1'b0;
    foreach (q[i]) begin
      chk("read_strobe", r_en, 1);
      chk("read_addr", r_addr, q[i]);
      chk("no_write_in_read", w_en, 0);
      chk("mode_q", mode_q, m);
      flag_40 = 1'($urandom % 2);
      tick();
      chk("wait_r_en", r_en, 0);
      chk("wait_w_en", w_en, 0);
      n = $urandom_range(0, 3);
      for (int k = 0; k < n; k++) begin
        flag_40  = 1'b0;
        enable   = 1'($urandom % 2);
        s_addr   = 8'($urandom);
        loc      = 8'($urandom);
        en_or_de = 1'($urandom % 2);
        tick();
        chk("wait_hold_w_en", w_en, 0);
        chk("wait_hold_r_en", r_en, 0);
      end
      flag_40 = 1'b1;
      enable  = hold && (i == q.size() - 1);
      tick();
      chk("write_strobe", w_en, 1);
      chk("write_addr", w_addr, q[i]);
      chk("no_read_in_write", r_en, 0);
      flag_40 = 1'($urandom % 2);
      tick();
      chk("next_w_en", w_en, 0);
      chk("next_r_en", r_en, 0);
      chk("next_de_fin", de_fin, 0);
      tick();
    end
    chk("done_pulse", de_fin, 1);
    chk("done_r_en", r_en, 0);
    chk("done_r_addr_hold", r_addr, q[q.size()-1]);
    chk("done_w_addr_hold", w_addr, q[q.size()-1]);
    tick();
    chk("idle_de_fin", de_fin, 0);
    chk("idle_r_en", r_en, 0);
    chk("idle_w_en", w_en, 0);
    chk("read_count", 32'(rd_cnt - r0), 32'(q.size()));
    chk("write_count", 32'(wr_cnt - w0), 32'(q.size()));
  endtask

  typedef struct {
    logic [7:0] s;
    logic [7:0] l;
    int         nblk;
    logic [7:0] last;
  } vec_t;

  vec_t tbl[8];

  initial begin
    int r0;
    int w0;
    tbl[0] = '{8'h10, 8'h10, 1, 8'h10};
    tbl[1] = '{8'h00, 8'h18, 4, 8'h18};
    tbl[2] = '{8'h20, 8'h08, 1, 8'h20};
    tbl[3] = '{8'hF8, 8'hFF, 1, 8'hF8};
    tbl[4] = '{8'hF0, 8'hFF, 2, 8'hF8};
    tbl[5] = '{8'h03, 8'h12, 3, 8'h13};
    tbl[6] = '{8'h00, 8'h07, 2, 8'h08};
    tbl[7] = '{8'hFF, 8'hFF, 1, 8'hFF};

    n_rst = 1'b1; enable = 1'b0; en_or_de = 1'b0;
    s_addr = 8'h00; loc = 8'h00; flag_40 = 1'b0;
    #1 n_rst = 1'b0;
    #1;
    chk("rst_r_en", r_en, 0);
    chk("rst_w_en", w_en, 0);
    chk("rst_de_fin", de_fin, 0);
    chk("rst_r_addr", r_addr, 0);
    chk("rst_w_addr", w_addr, 0);
    tick();
    tick();
    n_rst = 1'b1;
    flag_40 = 1'b1;
    tick();
    tick();
    chk("idle_spurious_flag", w_en, 0);
    chk("idle_no_start", r_en, 0);
    flag_40 = 1'b0;

    foreach (tbl[i]) begin
      r0 = rd_cnt;
      w0 = wr_cnt;
      run_job(tbl[i].s, tbl[i].l, 1'(i % 2), 1'b0);
      chk("tbl_blocks", 32'(rd_cnt - r0), 32'(tbl[i].nblk));
      chk("tbl_writes", 32'(wr_cnt - w0), 32'(tbl[i].nblk));
      chk("tbl_last_addr", w_addr, tbl[i].last);
    end

    // enable held high through DONE restarts directly from IDLE
    run_job(8'h30, 8'h38, 1'b1, 1'b1);
    run_job(8'h50, 8'h50, 1'b0, 1'b0);

    for (int j = 0; j < 12; j++) begin
      logic [7:0] s;
      logic [7:0] l;
      s = 8'($urandom);
      l = ($urandom % 4 == 0) ? 8'($urandom) : 8'(s + 8'($urandom_range(0, 40)));
      run_job(s, l, 1'($urandom % 2), 1'($urandom % 2));
    end

    // reset asserted mid-WAIT
    enable = 1'b1; s_addr = 8'h40; loc = 8'h60; en_or_de = 1'b1; flag_40 = 1'b0;
    tick();
    enable = 1'b0;
    tick();
    tick();
    chk("pre_rst_r_addr", r_addr, 8'h40);
    r0 = rd_cnt;
    w0 = wr_cnt;
    #3 n_rst = 1'b0;
    #1;
    chk("async_rst_r_en", r_en, 0);
    chk("async_rst_w_en", w_en, 0);
    chk("async_rst_de_fin", de_fin, 0);
    chk("async_rst_r_addr", r_addr, 0);
    chk("async_rst_w_addr", w_addr, 0);
    chk("async_rst_mode", mode_q, 0);
    flag_40 = 1'b1;
    tick();
    n_rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("post_rst_no_write", w_en, 0);
      chk("post_rst_no_read", r_en, 0);
    end
    chk("post_rst_writes", 32'(wr_cnt - w0), 0);
    chk("post_rst_reads", 32'(rd_cnt - r0), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
